// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO issue-and-writeback controller.
//   hilo_op_t    : EX-stage HI/LO-class opcode (3 bits; 5-7 are treated as NONE)
//   hilo_state_t : controller FSM states
//   DIV_LATENCY  : cycles from the divider start pulse to its complete strobe
package hilo_pkg;

  typedef enum logic [2:0] {
    HILO_NONE = 3'd0,
    HILO_DIV  = 3'd1,
    HILO_DIVU = 3'd2,
    HILO_MTHI = 3'd3,
    HILO_MTLO = 3'd4
  } hilo_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_t;

  localparam int unsigned DIV_LATENCY = 9;

endpackage

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: issue/writeback controller between EX and the iterative
// divider. Launches DIV/DIVU with a one-cycle start pulse, stalls EX until the
// divider's complete strobe, then writes quotient to LO and remainder to HI.
// MTHI/MTLO write HI/LO directly. HI/LO feed the MFHI/MFLO read path.
// Ports:
//   clk, resetn            : clock, async active-low reset
//   op_valid, op_code      : EX instruction valid and HI/LO opcode
//   op_a, op_b             : rs (dividend / move source), rt (divisor)
//   flush                  : cancel EX instruction and any divide in flight
//   stall                  : hold EX this cycle
//   hi, lo                 : architectural HI/LO registers
//   div_start              : one-cycle divider launch pulse
//   div_signed_o, div_x/y  : divider mode and raw operands (valid with div_start)
//   div_q, div_r           : divider quotient / remainder
//   div_complete           : one-cycle divider completion strobe
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        div_signed_o,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  import hilo_pkg::*;

  hilo_state_t state, next_state;
  logic        is_div;

  assign is_div = (op_code == HILO_DIV) || (op_code == HILO_DIVU);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && op_valid && !flush) begin
        if (op_code == HILO_MTHI) hi <= op_a;
        if (op_code == HILO_MTLO) lo <= op_a;
      end
      // A complete strobe seen in IDLE belongs to an abandoned divide.
      if (state == BUSY && div_complete && !flush) begin
        lo <= div_q;
        hi <= div_r;
      end
    end
  end

  // Outputs are gated by resetn so they stay quiet during reset regardless
  // of what EX presents.
  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    div_start    = 1'b0;
    div_signed_o = 1'b0;
    div_x        = '0;
    div_y        = '0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (op_valid && !flush && is_div) begin
            div_start    = 1'b1;
            stall        = 1'b1;
            div_signed_o = (op_code == HILO_DIV);
            div_x        = op_a;
            div_y        = op_b;
            next_state   = BUSY;
          end
        end
        BUSY: begin
          if (flush || div_complete) next_state = IDLE;
          else                       stall      = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  a_no_start_in_busy : assert property (@(posedge clk) disable iff (!resetn)
    !(state == BUSY && div_start));

  a_no_idle_stall : assert property (@(posedge clk) disable iff (!resetn)
    !(state == IDLE && stall && !div_start));

  a_complete_timing : assert property (@(posedge clk) disable iff (!resetn)
    (state == BUSY && div_complete && !flush) |-> $past(div_start, DIV_LATENCY));

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Issue-and-writeback controller between the EX stage and the iterative divider. Accepts DIV/DIVU/MTHI/MTLO from EX and launches the divider with a one-cycle start pulse. Stalls EX until the divider's one-cycle `complete` strobe arrives, then captures quotient/remainder into the architectural LO/HI registers. Also supplies HI/LO to the MFHI/MFLO read path.

## Interface
- Parameters: none; operation codes come from `hilo_pkg`.
- `clk` in 1: single clock, shared with the divider.
- `resetn` in 1: asynchronous, active-low reset.
- `op_valid` in 1: EX holds a valid HI/LO-class instruction.
- `op_code` in 3: `HILO_NONE`=0, `HILO_DIV`=1, `HILO_DIVU`=2, `HILO_MTHI`=3, `HILO_MTLO`=4; values 5-7 are treated as NONE.
- `op_a` in 32: rs value (dividend, or MTHI/MTLO source).
- `op_b` in 32: rt value (divisor).
- `flush` in 1: cancels the current EX instruction and any divide in flight.
- `stall` out 1: hold EX/upstream this cycle.
- `hi` out 32, `lo` out 32: architectural HI/LO, registered.
- `div_start` out 1: one-cycle launch pulse; drives divider `div`.
- `div_signed_o` out 1, `div_x` out 32, `div_y` out 32: divider operands; valid while `div_start`=1.
- `div_q` in 32, `div_r` in 32, `div_complete` in 1: divider quotient, remainder, completion strobe.

## Operation
- States: IDLE, BUSY.
- **IDLE, DIV/DIVU, no flush**
  - Combinationally assert `div_start`=1 and `stall`=1.
  - Drive `div_x`=op_a, `div_y`=op_b, and `div_signed_o`=(op_code==DIV). Sign handling lives in the divider; operands pass through raw.
  - Move to BUSY at the clock edge.
- **IDLE, MTHI/MTLO, no flush**: `hi`<=op_a or `lo`<=op_a at the edge; no stall.
- **IDLE with flush**: no pulse, no stall, no register write.
- **BUSY**
  - `div_start`=0 even though the same instruction stays presented.
  - `stall`=1 while `div_complete`=0.
  - On `div_complete`=1: `stall`=0; at that edge `lo`<=div_q, `hi`<=div_r, return to IDLE. The EX instruction advances on the same edge.
- **flush in BUSY**: `stall`=0 that cycle; return to IDLE at the edge with no write.
  - The abandoned divide keeps running; its later `complete` arrives in IDLE and is ignored.
  - A new `div_start` restarts the divider's counter, so no stale strobe can land in a later BUSY.
- **`div_complete` while in IDLE**: ignored.
- **Divide by zero**: whatever the divider returns is written. There is no trap.
- **Reset**: state=IDLE, `hi`=0, `lo`=0. Outputs settle to `stall`=0, `div_start`=0, `div_x`=`div_y`=0, `div_signed_o`=0, independent of inputs while `resetn`=0.

## Timing
- Divider contract: `div_start` sampled at edge E0; `div_complete` is high for exactly one cycle, the 9th cycle after the pulse cycle. Results are valid only in that cycle, so they are captured at that edge.
- DIV occupancy is 10 cycles: pulse cycle + 8 BUSY cycles with `stall`=1, then the complete cycle with `stall`=0. That gives 9 stall cycles.
- `hi`/`lo` update at the completing edge. MFHI/MFLO in the following cycle sees the new values; there is no internal bypass.
- Back-to-back DIVs: the second can pulse in the cycle right after the first completes, because the state is IDLE again.
- Asynchronous reset mid-BUSY clears everything immediately. The divider's own reset is driven by the same `resetn`.

## Structure
- `hilo_pkg`: `hilo_op_t` opcode enum (3 bits), `hilo_state_t` {IDLE, BUSY}, `DIV_LATENCY`=9 (used only by assertions).
- No sub-module. The divider is a sibling instance wired by the EX-stage top; this block holds only the FSM plus the HI/LO registers.
- Assertions:
  - `div_start` is never high in BUSY.
  - `stall` is never high in IDLE without `div_start`.

## Test plan
- DIVU 100/7 in IDLE: `div_start` for 1 cycle, `stall` 9 cycles, then LO=14, HI=2.
- DIV 0xFFFFFFF9 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands: LO=0x7FFFFFFC, HI=1.
- MTHI 0xDEADBEEF then MTLO 0x12345678: `hi`/`lo` update one edge each, `stall` stays 0, no `div_start`.
- DIV 50/5, flush on the 4th BUSY cycle: `stall` drops that cycle; HI/LO keep their previous values; the late `div_complete` causes no write.
- Two consecutive DIVU (9/2 then 20/6): second pulse in the cycle after the first complete. Final LO=3, HI=2, 20 cycles total.
- `resetn` low mid-BUSY: `stall`, `div_start`, `hi`, `lo` go to 0 asynchronously; after release a DIVU 8/3 gives LO=2, HI=2.
